cp_corr: RTL

Sliding-window cyclic-prefix correlator. First stage of the DICD timing/CFO estimator, directly upstream of the magnitude/angle and likelihood stages. For each received complex sample it produces:
- the CP correlation gamma(k) = sum over m=0..L-1 of r(k-m)·conj(r(k-m-N));
- the energy term phi(k) = ½·sum over m=0..L-1 of (|r(k-m)|² + |r(k-m-N)|²);
- the sample's timing index theta within the N+L symbol.

---
 rtl/cp_corr_pkg.sv | 42 ++++
 rtl/cp_corr_delay_line.sv | 48 ++++
 rtl/cp_corr.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cp_corr_pkg.sv
// Shared types, constants and complex-arithmetic helpers for the cyclic-prefix
// correlator of the DICD timing/CFO estimator.
package cp_corr_pkg;

   localparam int unsigned CP_N       = 128;
   localparam int unsigned CP_L       = 16;
   localparam int unsigned CORR_ACC_W = 15 + $clog2(CP_L);

   typedef logic signed [6:0]  r_t;      // Q1.6
   typedef logic signed [13:0] gamma_t;  // Q6.8
   typedef logic signed [13:0] phi_t;    // Q6.8, never negative
   typedef logic        [7:0]  theta_t;
   typedef logic signed [14:0] prod_t;   // Q3.12
   // Four full-scale squares sum to exactly 2^14, so energy is kept unsigned.
   typedef logic        [14:0] energy_t;

   typedef struct packed {
      r_t re;
      r_t im;
   } cplx_t;

   typedef struct packed {
      prod_t re;
      prod_t im;
   } cprod_t;

   function automatic cprod_t mul_conj(cplx_t a, cplx_t b);
      cprod_t p;
      p.re = prod_t'(a.re) * prod_t'(b.re) + prod_t'(a.im) * prod_t'(b.im);
      p.im = prod_t'(a.im) * prod_t'(b.re) - prod_t'(a.re) * prod_t'(b.im);
      return p;
   endfunction

   function automatic energy_t pair_energy(cplx_t a, cplx_t b);
      prod_t ea;
      prod_t eb;
      ea = prod_t'(a.re) * prod_t'(a.re) + prod_t'(a.im) * prod_t'(a.im);
      eb = prod_t'(b.re) * prod_t'(b.re) + prod_t'(b.im) * prod_t'(b.im);
      return energy_t'(ea) + energy_t'(eb);
   endfunction

endpackage

// File: rtl/cp_corr_delay_line.sv
// Circular buffer of the last N+L complex samples with taps N, L and N+L
// samples behind the slot about to be written.
module cp_delay_line
   import cp_corr_pkg::*;
#(
   parameter int unsigned N = CP_N,
   parameter int unsigned L = CP_L
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [13:0] din_i,
   output logic [13:0] tap_n_o,
   output logic [13:0] tap_l_o,
   output logic [13:0] tap_ln_o
);

   localparam int unsigned D  = N + L;
   localparam int unsigned AW = $clog2(D);

   logic [13:0]   mem_q [D];
   logic [AW-1:0] wp_q;
   logic [AW-1:0] wp_d;

   function automatic logic [AW-1:0] behind(logic [AW-1:0] wp, int unsigned off);
      int unsigned a;
      a = 32'(wp) + D - off;
      if (a >= D) a = a - D;
      return AW'(a);
   endfunction

   assign wp_d = (wp_q == AW'(D - 1)) ? '0 : wp_q + AW'(1);

   // Reads see the old contents, so the N+L tap is the slot being overwritten.
   assign tap_n_o  = mem_q[behind(wp_q, N)];
   assign tap_l_o  = mem_q[behind(wp_q, L)];
   assign tap_ln_o = mem_q[behind(wp_q, D)];

   always_ff @(posedge clk) begin
      if (rst)       wp_q <= '0;
      else if (we_i) wp_q <= wp_d;
   end

   always_ff @(posedge clk) begin
      if (we_i) mem_q[wp_q] <= din_i;
   end

endmodule

// File: rtl/cp_corr.sv
// Sliding-window cyclic-prefix correlator: running CP correlation, energy term
// and timing index, two pipeline stages from accepted sample to output.
module cp_corr
   import cp_corr_pkg::*;
#(
   parameter int unsigned N = CP_N,
   parameter int unsigned L = CP_L
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic signed [6:0]  r_re,
   input  logic signed [6:0]  r_im,
   output logic               out_valid,
   output logic signed [13:0] gamma_re,
   output logic signed [13:0] gamma_im,
   output logic signed [13:0] phi,
   output logic        [7:0]  theta
);

   localparam int unsigned D     = N + L;
   localparam int unsigned ACC_W = 15 + $clog2(L);
   localparam int unsigned FW    = $clog2(D + 1);

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic        [ACC_W-1:0] acce_t;

   cplx_t         cur, tap_n, tap_l, tap_ln;
   cplx_t         new_b, old_a, old_b;
   logic [FW-1:0] fill_q, fill_d;
   theta_t        tcnt_q, tcnt_d;

   logic          s1_vld_q, s1_full_q;
   theta_t        s1_theta_q;
   cprod_t        pn_q, po_q;
   energy_t       en_q, eo_q;

   acc_t          acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   acce_t         acc_e_q, acc_e_d;
   logic          out_valid_q;
   gamma_t        gamma_re_q, gamma_im_q;
   phi_t          phi_q;
   theta_t        theta_q;

   function automatic gamma_t sat_gamma(acc_t a);
      acc_t s;
      s = a >>> 4;
      if (s > acc_t'(8191))  return gamma_t'(8191);
      if (s < acc_t'(-8192)) return gamma_t'(-8192);
      return gamma_t'(s);
   endfunction

   function automatic phi_t sat_phi(acce_t a);
      acce_t s;
      s = a >> 5;
      if (s > acce_t'(8191)) return phi_t'(8191);
      return phi_t'(s);
   endfunction

   cp_delay_line #(.N(N), .L(L)) u_dly (
      .clk      (clk),
      .rst      (rst),
      .we_i     (in_valid),
      .din_i    (cur),
      .tap_n_o  (tap_n),
      .tap_l_o  (tap_l),
      .tap_ln_o (tap_ln)
   );

   // Taps reaching back before the first post-reset sample read as zero.
   always_comb begin
      cur    = '{re: r_re, im: r_im};
      new_b  = (fill_q >= FW'(N)) ? tap_n  : '0;
      old_a  = (fill_q >= FW'(L)) ? tap_l  : '0;
      old_b  = (fill_q == FW'(D)) ? tap_ln : '0;
      fill_d = fill_q;
      tcnt_d = tcnt_q;
      if (in_valid) begin
         if (fill_q != FW'(D)) fill_d = fill_q + FW'(1);
         tcnt_d = (tcnt_q == theta_t'(D - 1)) ? '0 : tcnt_q + theta_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q   <= '0;
         tcnt_q   <= '0;
         s1_vld_q <= 1'b0;
      end else begin
         fill_q   <= fill_d;
         tcnt_q   <= tcnt_d;
         s1_vld_q <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         s1_full_q  <= (fill_q == FW'(D));
         s1_theta_q <= tcnt_q;
         pn_q       <= mul_conj(cur, new_b);
         po_q       <= mul_conj(old_a, old_b);
         en_q       <= pair_energy(cur, new_b);
         eo_q       <= pair_energy(old_a, old_b);
      end
   end

   always_comb begin
      acc_re_d = acc_re_q + acc_t'(pn_q.re) - acc_t'(po_q.re);
      acc_im_d = acc_im_q + acc_t'(pn_q.im) - acc_t'(po_q.im);
      acc_e_d  = acc_e_q + acce_t'(en_q) - acce_t'(eo_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_re_q    <= '0;
         acc_im_q    <= '0;
         acc_e_q     <= '0;
         out_valid_q <= 1'b0;
         gamma_re_q  <= '0;
         gamma_im_q  <= '0;
         phi_q       <= '0;
         theta_q     <= '0;
      end else begin
         out_valid_q <= s1_vld_q & s1_full_q;
         if (s1_vld_q) begin
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            acc_e_q    <= acc_e_d;
            gamma_re_q <= sat_gamma(acc_re_d);
            gamma_im_q <= sat_gamma(acc_im_d);
            phi_q      <= sat_phi(acc_e_d);
            theta_q    <= s1_theta_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign gamma_re  = gamma_re_q;
   assign gamma_im  = gamma_im_q;
   assign phi       = phi_q;
   assign theta     = theta_q;

endmodule
